// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int SIZELOAD_W = 3;
  localparam int MEMWRITE_W = 2;

  localparam logic [SIZELOAD_W-1:0] SIZELOAD_WORD = 3'b010;

  localparam logic [1:0] GRANT_NONE  = 2'b00;
  localparam logic [1:0] GRANT_FETCH = 2'b01;
  localparam logic [1:0] GRANT_DATA  = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way tie breaker: fetch vs data, either fixed data priority or
// alternating against whoever was served last.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIORITY = 0
) (
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       last_data,
  output logic [1:0] grant
);

  // One-hot grant; on a tie data wins unless it was the last one served
  always_comb begin
    grant = GRANT_NONE;
    if (fetch_req && data_req) begin
      if ((DATA_PRIORITY != 0) || !last_data) begin
        grant = GRANT_DATA;
      end else begin
        grant = GRANT_FETCH;
      end
    end else if (data_req) begin
      grant = GRANT_DATA;
    end else if (fetch_req) begin
      grant = GRANT_FETCH;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one UART memory link between the instruction-fetch port and the
// data port. One transaction is in flight at a time; operands are latched
// at grant and held until the link reports completion.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_done,
  output logic [31:0]           i_rdata,
  input  logic                  d_re,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [SIZELOAD_W-1:0] d_sizeload,
  input  logic [MEMWRITE_W-1:0] d_memwrite,
  output logic                  d_done,
  output logic [31:0]           d_rdata,
  output logic                  m_read_enable,
  output logic                  m_write_enable,
  output logic [31:0]           m_address,
  output logic [31:0]           m_writeData,
  output logic [SIZELOAD_W-1:0] m_SizeLoad,
  output logic [MEMWRITE_W-1:0] m_MemWrite,
  input  logic                  m_mem_done,
  input  logic [31:0]           m_readData,
  output logic                  busy
);

  arb_state_t state;
  arb_state_t state_next;

  logic       data_req;
  logic [1:0] grant;
  logic       last_grant_data;
  logic       cur_data;
  logic       cur_read;
  logic       start;
  logic       finish;

  assign data_req = d_re | d_we;

  rr_arb2 #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_rr_arb2 (
    .fetch_req(i_req),
    .data_req (data_req),
    .last_data(last_grant_data),
    .grant    (grant)
  );

  // State register; reset aborts any in-flight transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: grant from IDLE, wait for the link, then one dead cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (grant != GRANT_NONE) state_next = ISSUE;
      ISSUE:    if (m_mem_done)          state_next = COMPLETE;
      COMPLETE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Control outputs: busy flag plus the grant and completion strobes
  always_comb begin
    busy   = (state != IDLE);
    start  = (state == IDLE) && (grant != GRANT_NONE);
    finish = (state == ISSUE) && m_mem_done;
  end

  // Link operand registers, read-data capture and done pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_read_enable   <= 1'b0;
      m_write_enable  <= 1'b0;
      m_address       <= '0;
      m_writeData     <= '0;
      m_SizeLoad      <= '0;
      m_MemWrite      <= '0;
      i_done          <= 1'b0;
      d_done          <= 1'b0;
      i_rdata         <= '0;
      d_rdata         <= '0;
      last_grant_data <= 1'b0;
      cur_data        <= 1'b0;
      cur_read        <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (start) begin
        cur_data <= (grant == GRANT_DATA);
        if (grant == GRANT_DATA) begin
          m_address      <= d_addr;
          m_writeData    <= d_wdata;
          m_SizeLoad     <= d_sizeload;
          m_MemWrite     <= d_memwrite;
          m_write_enable <= d_we;
          m_read_enable  <= ~d_we;
          cur_read       <= ~d_we;
        end else begin
          m_address      <= i_addr;
          m_writeData    <= '0;
          m_SizeLoad     <= SIZELOAD_WORD;
          m_MemWrite     <= '0;
          m_write_enable <= 1'b0;
          m_read_enable  <= 1'b1;
          cur_read       <= 1'b1;
        end
      end else if (finish) begin
        m_read_enable   <= 1'b0;
        m_write_enable  <= 1'b0;
        last_grant_data <= cur_data;
        if (cur_data) begin
          d_done <= 1'b1;
          if (cur_read) d_rdata <= m_readData;
        end else begin
          i_done  <= 1'b1;
          i_rdata <= m_readData;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one round-robin instance and one
// data-priority instance share request inputs; the bench plays the link.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_re;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_sizeload;
  logic [1:0]  d_memwrite;
  logic        linkDone;
  logic [31:0] linkRdata;
  logic        sel1;

  logic        memDone0, memDone1;
  logic        iDone0, dDone0, ren0, wen0, busy0;
  logic        iDone1, dDone1, ren1, wen1, busy1;
  logic [31:0] iRdata0, dRdata0, addr0, wdata0;
  logic [31:0] iRdata1, dRdata1, addr1, wdata1;
  logic [2:0]  size0, size1;
  logic [1:0]  mw0, mw1;

  logic        vRen, vWen, vIdone, vDdone, vBusy;
  logic [31:0] vAddr, vWdata, vIrdata, vDrdata;
  logic [2:0]  vSize;
  logic [1:0]  vMw;

  logic [31:0] sAddr, sWdata;
  logic [2:0]  sSize;
  logic [1:0]  sMw;
  logic        sRen, sWen, sDoneI, sDoneD, sEnAfter;

  int checks = 0;
  int errors = 0;

  assign memDone0 = linkDone & ~sel1;
  assign memDone1 = linkDone & sel1;

  assign vRen    = sel1 ? ren1    : ren0;
  assign vWen    = sel1 ? wen1    : wen0;
  assign vIdone  = sel1 ? iDone1  : iDone0;
  assign vDdone  = sel1 ? dDone1  : dDone0;
  assign vBusy   = sel1 ? busy1   : busy0;
  assign vAddr   = sel1 ? addr1   : addr0;
  assign vWdata  = sel1 ? wdata1  : wdata0;
  assign vIrdata = sel1 ? iRdata1 : iRdata0;
  assign vDrdata = sel1 ? dRdata1 : dRdata0;
  assign vSize   = sel1 ? size1   : size0;
  assign vMw     = sel1 ? mw1     : mw0;

  mem_port_arbiter #(.DATA_PRIORITY(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(iDone0), .i_rdata(iRdata0),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sizeload(d_sizeload), .d_memwrite(d_memwrite),
    .d_done(dDone0), .d_rdata(dRdata0),
    .m_read_enable(ren0), .m_write_enable(wen0),
    .m_address(addr0), .m_writeData(wdata0),
    .m_SizeLoad(size0), .m_MemWrite(mw0),
    .m_mem_done(memDone0), .m_readData(linkRdata),
    .busy(busy0)
  );

  mem_port_arbiter #(.DATA_PRIORITY(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(iDone1), .i_rdata(iRdata1),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sizeload(d_sizeload), .d_memwrite(d_memwrite),
    .d_done(dDone1), .d_rdata(dRdata1),
    .m_read_enable(ren1), .m_write_enable(wen1),
    .m_address(addr1), .m_writeData(wdata1),
    .m_SizeLoad(size1), .m_MemWrite(mw1),
    .m_mem_done(memDone1), .m_readData(linkRdata),
    .busy(busy1)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drives all requester-side inputs at once
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dre, input logic dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input logic [2:0] dsize, input logic [1:0] dmw);
    i_req      = ireq;
    i_addr     = iaddr;
    d_re       = dre;
    d_we       = dwe;
    d_addr     = daddr;
    d_wdata    = dwdata;
    d_sizeload = dsize;
    d_memwrite = dmw;
  endtask

  // Plays the link for one transaction: wait for an enable, snapshot the
  // operands, hold for the given delay, then pulse completion
  task automatic serveOne(input string tag, input logic [31:0] rdata, input int delay);
    int n;
    n = 0;
    while (!(vRen || vWen) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_issued"}, 32'(vRen | vWen), 32'd1);
    sAddr  = vAddr;
    sWdata = vWdata;
    sSize  = vSize;
    sMw    = vMw;
    sRen   = vRen;
    sWen   = vWen;
    repeat (delay) @(negedge clk);
    checkOutput({tag, "_held"}, 32'({vRen, vWen, vAddr == sAddr, vBusy}),
                32'({sRen, sWen, 1'b1, 1'b1}));
    linkDone  = 1'b1;
    linkRdata = rdata;
    @(negedge clk);
    linkDone  = 1'b0;
    sDoneI    = vIdone;
    sDoneD    = vDdone;
    sEnAfter  = vRen | vWen;
    checkOutput({tag, "_enables_dropped"}, 32'(sEnAfter), 32'd0);
    checkOutput({tag, "_done_exclusive"}, 32'(sDoneI & sDoneD), 32'd0);
  endtask

  logic [31:0] tieAddr [4];
  logic [31:0] tieData [4];
  int n;

  initial begin
    tieAddr[0] = 32'h2000; tieAddr[1] = 32'h1000;
    tieAddr[2] = 32'h2000; tieAddr[3] = 32'h1000;
    tieData[0] = 32'hD0D0_0001; tieData[1] = 32'h1111_0002;
    tieData[2] = 32'hD0D0_0003; tieData[3] = 32'h1111_0004;

    sel1      = 1'b0;
    linkDone  = 1'b0;
    linkRdata = '0;
    reset     = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);

    // Reset state
    @(negedge clk);
    checkOutput("rst_busy", 32'(vBusy), 32'd0);
    checkOutput("rst_enables", 32'({vRen, vWen}), 32'd0);
    checkOutput("rst_dones", 32'({vIdone, vDdone}), 32'd0);
    checkOutput("rst_irdata", vIrdata, 32'd0);
    checkOutput("rst_drdata", vDrdata, 32'd0);
    checkOutput("rst_operands", 32'({vAddr != 0, vWdata != 0, vSize, vMw}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Round-robin tie with both requests held: D, I, D, I
    applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0, 3'b010, 2'd0);
    for (int k = 0; k < 4; k++) begin
      serveOne($sformatf("tie%0d", k), tieData[k], 2);
      checkOutput($sformatf("tie%0d_addr", k), sAddr, tieAddr[k]);
      if (tieAddr[k] == 32'h2000) begin
        checkOutput($sformatf("tie%0d_ddone", k), 32'({sDoneI, sDoneD}), 32'b01);
        checkOutput($sformatf("tie%0d_drdata", k), vDrdata, tieData[k]);
      end else begin
        checkOutput($sformatf("tie%0d_idone", k), 32'({sDoneI, sDoneD}), 32'b10);
        checkOutput($sformatf("tie%0d_irdata", k), vIrdata, tieData[k]);
      end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);

    // Fetch only, 20-cycle link
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, '0, '0, '0, '0);
    serveOne("fetch", 32'hDEADBEEF, 20);
    checkOutput("fetch_addr", sAddr, 32'h40);
    checkOutput("fetch_enables", 32'({sRen, sWen}), 32'b10);
    checkOutput("fetch_size", 32'(sSize), 32'd2);
    checkOutput("fetch_memwrite", 32'(sMw), 32'd0);
    checkOutput("fetch_dones", 32'({sDoneI, sDoneD}), 32'b10);
    checkOutput("fetch_irdata", vIrdata, 32'hDEADBEEF);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("fetch_pulse_width", 32'({vIdone, vDdone}), 32'd0);
    checkOutput("fetch_back_idle", 32'(vBusy), 32'd0);

    // Store word
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h100, 32'h12345678, 3'b000, 2'd2);
    serveOne("store", 32'h5555_5555, 5);
    checkOutput("store_enables", 32'({sRen, sWen}), 32'b01);
    checkOutput("store_addr", sAddr, 32'h100);
    checkOutput("store_wdata", sWdata, 32'h12345678);
    checkOutput("store_memwrite", 32'(sMw), 32'd2);
    checkOutput("store_dones", 32'({sDoneI, sDoneD}), 32'b01);
    checkOutput("store_drdata", vDrdata, 32'hD0D0_0003);
    checkOutput("store_irdata", vIrdata, 32'hDEADBEEF);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);

    // Spurious link completion while idle
    linkDone  = 1'b1;
    linkRdata = 32'hBAD0_BAD0;
    @(negedge clk);
    linkDone  = 1'b0;
    checkOutput("spur_dones", 32'({vIdone, vDdone}), 32'd0);
    checkOutput("spur_busy", 32'(vBusy), 32'd0);
    @(negedge clk);
    checkOutput("spur_dones_late", 32'({vIdone, vDdone}), 32'd0);
    checkOutput("spur_irdata", vIrdata, 32'hDEADBEEF);
    checkOutput("spur_drdata", vDrdata, 32'hD0D0_0003);

    // Read and write both high: becomes a write
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 3'b010, 2'd1);
    serveOne("dual", 32'h7777_7777, 2);
    checkOutput("dual_enables", 32'({sRen, sWen}), 32'b01);
    checkOutput("dual_addr", sAddr, 32'h300);
    checkOutput("dual_wdata", sWdata, 32'hA5A5A5A5);
    checkOutput("dual_memwrite", 32'(sMw), 32'd1);
    checkOutput("dual_dones", 32'({sDoneI, sDoneD}), 32'b01);
    checkOutput("dual_drdata", vDrdata, 32'hD0D0_0003);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);

    // Reset in the middle of an issued fetch
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, '0, '0);
    n = 0;
    while (!vRen && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_issued", 32'(vRen), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_enables", 32'({vRen, vWen}), 32'd0);
    checkOutput("midrst_busy", 32'(vBusy), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("midrst_dones", 32'({vIdone, vDdone}), 32'd0);
    checkOutput("midrst_irdata", vIrdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_no_late_done", 32'({vIdone, vDdone, vBusy}), 32'd0);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, '0, '0);
    serveOne("fresh", 32'hCAFEF00D, 3);
    checkOutput("fresh_addr", sAddr, 32'h80);
    checkOutput("fresh_dones", 32'({sDoneI, sDoneD}), 32'b10);
    checkOutput("fresh_irdata", vIrdata, 32'hCAFEF00D);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);

    // Data-priority instance: data wins every tie until it drops
    reset = 1'b0;
    sel1  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0, 3'b010, 2'd0);
    for (int k = 0; k < 3; k++) begin
      serveOne($sformatf("prio%0d", k), 32'hE0E0_0000 + 32'(k), 2);
      checkOutput($sformatf("prio%0d_addr", k), sAddr, 32'h2000);
      checkOutput($sformatf("prio%0d_dones", k), 32'({sDoneI, sDoneD}), 32'b01);
    end
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, '0, '0, '0, '0);
    serveOne("prio_fetch", 32'h9999_9999, 2);
    checkOutput("prio_fetch_addr", sAddr, 32'h1000);
    checkOutput("prio_fetch_dones", 32'({sDoneI, sDoneD}), 32'b10);
    checkOutput("prio_fetch_irdata", vIrdata, 32'h9999_9999);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one parameter: DATA_PRIORITY, default 0; 0 = round-robin between requesters, 1 = data port always wins ties.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  instruction-fetch read request; held high until i_done.
REQ-005 i_addr  input  32  fetch address; stable while i_req is high.
REQ-006 i_done  output  1  one-cycle pulse; fetch complete, i_rdata valid.
REQ-007 i_rdata  output  32  fetched word; registered, held until the next fetch completes.
REQ-008 d_re, d_we  input  1 each  data read and data write requests; held until d_done.
REQ-009 d_addr, d_wdata  input  32 each  data address and store data.
REQ-010 d_sizeload  input  3  load size code; d_memwrite  input  2  store size code.
REQ-011 d_done  output  1  one-cycle pulse; d_rdata  output  32  load result, held until the next data read completes.
REQ-012 m_read_enable, m_write_enable  output  1 each  request to the UART memory link.
REQ-013 m_address, m_writeData  output  32 each; m_SizeLoad  output  3; m_MemWrite  output  2  link operands.
REQ-014 m_mem_done  input  1  link completion pulse; m_readData  input  32  valid in the m_mem_done cycle.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE, COMPLETE.
REQ-017 IDLE: if any request is pending, latch the winner's operands into the m_* registers, set the matching m_*_enable, and go to ISSUE at the next edge; otherwise stay in IDLE.
REQ-018 Fetch grants SHALL drive m_read_enable=1, m_SizeLoad=3'b010 (word) and m_MemWrite=0.
REQ-019 A data grant with d_we=1 SHALL drive m_write_enable=1; otherwise it SHALL drive m_read_enable=1. If d_we and d_re are both high, the write wins and the read is ignored.
REQ-020 Tie resolution with DATA_PRIORITY=0: grant the requester not served last; a last_grant flag SHALL reset to "instruction", so the first tie goes to data.
REQ-021 ISSUE: the m_* outputs and enable SHALL stay constant until m_mem_done=1.
REQ-022 On the m_mem_done edge: clear both enables, capture m_readData into i_rdata or d_rdata on reads only, pulse the matching done for one cycle, update last_grant, and go to COMPLETE.
REQ-023 Enables SHALL be low in the cycle after m_mem_done, so the link never re-triggers.
REQ-024 COMPLETE: no request SHALL be sampled, giving the requester one cycle to drop its request; go to IDLE at the next edge.
REQ-025 Minimum latency from request to done pulse SHALL be 2 clocks plus the link time.
REQ-026 m_mem_done seen in IDLE or COMPLETE SHALL be ignored; it SHALL cause no done pulse and no rdata change.
REQ-027 Requests raised or dropped during ISSUE SHALL NOT alter the in-flight transaction.
REQ-028 i_done and d_done SHALL never be high in the same cycle.

Reset
REQ-029 While reset is low: state=IDLE, all m_* outputs=0, i_done=d_done=0, i_rdata=d_rdata=0, busy=0, last_grant=instruction.
REQ-030 Reset asserted mid-ISSUE SHALL drop the enables immediately with no done pulse; the link SHALL share the same reset so both restart clean.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state encoding, the SizeLoad and MemWrite widths, and the word SizeLoad constant 3'b010.
REQ-032 Tie resolution SHALL live in one sub-module, rr_arb2: two requests, DATA_PRIORITY, last_grant -> one-hot grant.

Verification
REQ-033 Fetch only: i_addr=0x0000_0040, link returns 0xDEADBEEF after 20 cycles -> m_read_enable=1, m_SizeLoad=2; i_done one pulse; i_rdata=0xDEADBEEF; d_done stays 0.
REQ-034 Store: d_we=1, d_addr=0x100, d_wdata=0x12345678, d_memwrite=2 -> m_write_enable=1 with these operands; d_done pulse; d_rdata unchanged.
REQ-035 Tie, DATA_PRIORITY=0, both requests held for 4 transactions -> grant order D, I, D, I.
REQ-036 Tie, DATA_PRIORITY=1 -> data granted on every tie; fetch granted only once data drops.
REQ-037 Reset pulse mid-ISSUE -> enables 0 during reset, no done pulse, busy=0; a fresh fetch afterwards completes normally.
REQ-038 Spurious m_mem_done in IDLE, plus d_we=d_re=1 -> no done pulse on the spurious pulse; the dual request becomes a write only.
